// File: rtl/program_loader.sv
// Writer side of program memory: holds the processor halted while load_mode is high.
// Each enter press writes the switch word to the next address until END_WORD arrives or memory fills.
module program_loader #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    MEM_DEPTH  = 32,
    parameter logic [DATA_WIDTH-1:0] END_WORD   = {DATA_WIDTH{1'b1}}
) (
    input  logic                  read_clock,
    input  logic                  reset,
    input  logic                  load_mode,
    input  logic                  enter,
    input  logic [DATA_WIDTH-1:0] entrada_switches,
    output logic                  we_memProg,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic [DATA_WIDTH-1:0] dataMemProg,
    output logic                  haltLoad,
    output logic                  cpu_start,
    output logic                  load_done,
    output logic                  load_full,
    output logic [ADDR_WIDTH-1:0] word_count,
    output logic [DATA_WIDTH-1:0] display_word
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_WORD,
        WRITE,
        DONE,
        FULL
    } state_t;

    state_t                state_q, state_d;
    logic                  enter_prev_q;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  halt_q, halt_d;
    logic                  start_q, start_d;
    logic                  done_q, done_d;
    logic                  full_q, full_d;
    logic [ADDR_WIDTH-1:0] count_q, count_d;
    logic [DATA_WIDTH-1:0] disp_q, disp_d;
    logic                  enter_rise;

    assign enter_rise = enter & ~enter_prev_q;

    always_ff @(posedge read_clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            enter_prev_q <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            halt_q       <= 1'b0;
            start_q      <= 1'b0;
            done_q       <= 1'b0;
            full_q       <= 1'b0;
            count_q      <= '0;
            disp_q       <= '0;
        end else begin
            state_q      <= state_d;
            enter_prev_q <= enter;
            we_q         <= we_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            halt_q       <= halt_d;
            start_q      <= start_d;
            done_q       <= done_d;
            full_q       <= full_d;
            count_q      <= count_d;
            disp_q       <= disp_d;
        end
    end

    // Every output is computed one cycle ahead from the next state so it leaves a flop.
    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        start_d = 1'b0;
        done_d  = done_q;
        full_d  = full_q;
        count_d = count_q;
        disp_d  = disp_q;

        unique case (state_q)
            IDLE: begin
                if (load_mode) begin
                    state_d = WAIT_WORD;
                    addr_d  = '0;
                    count_d = '0;
                    done_d  = 1'b0;
                    full_d  = 1'b0;
                end
            end
            WAIT_WORD: begin
                if (!load_mode) begin
                    state_d = IDLE;
                end else if (enter_rise) begin
                    data_d = entrada_switches;
                    disp_d = entrada_switches;
                    if (entrada_switches == END_WORD) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = WRITE;
                        we_d    = 1'b1;
                    end
                end
            end
            WRITE: begin
                count_d = count_q + ONE;
                if (addr_q == LAST_ADDR) begin
                    state_d = FULL;
                    full_d  = 1'b1;
                end else begin
                    state_d = WAIT_WORD;
                    addr_d  = addr_q + ONE;
                end
            end
            DONE: begin
                if (!load_mode) begin
                    state_d = IDLE;
                    start_d = 1'b1;
                end
            end
            FULL: begin
                if (!load_mode) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        halt_d = (state_d != IDLE);
    end

    assign we_memProg   = we_q;
    assign write_addr   = addr_q;
    assign dataMemProg  = data_q;
    assign haltLoad     = halt_q;
    assign cpu_start    = start_q;
    assign load_done    = done_q;
    assign load_full    = full_q;
    assign word_count   = count_q;
    assign display_word = disp_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a small program-memory model records every write and
// cpu_start pulse; each step compares outputs against hand-computed values.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_mode = 1'b0;
    logic        enter = 1'b0;
    logic [15:0] sw = 16'h0000;
    logic        we;
    logic [15:0] waddr;
    logic [15:0] wdata;
    logic        halt;
    logic        start;
    logic        done;
    logic        full;
    logic [15:0] wcount;
    logic [15:0] disp;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] mem [0:31];
    int          writes = 0;
    int          starts = 0;
    int          ffff_writes = 0;
    logic [15:0] last_addr = 16'h0;
    int          w0, s0;

    program_loader dut (
        .read_clock      (clk),
        .reset           (rst),
        .load_mode       (load_mode),
        .enter           (enter),
        .entrada_switches(sw),
        .we_memProg      (we),
        .write_addr      (waddr),
        .dataMemProg     (wdata),
        .haltLoad        (halt),
        .cpu_start       (start),
        .load_done       (done),
        .load_full       (full),
        .word_count      (wcount),
        .display_word    (disp)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (we) begin
            mem[waddr[4:0]] <= wdata;
            last_addr <= waddr;
            writes <= writes + 1;
            if (wdata == 16'hFFFF) ffff_writes <= ffff_writes + 1;
        end
        if (start) starts <= starts + 1;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [15:0] w);
        sw    = w;
        enter = 1'b1;
        step(1);
        enter = 1'b0;
        step(3);
    endtask

    initial begin
        // Reset state
        step(3);
        check("rst_we", we, 0);
        check("rst_halt", halt, 0);
        check("rst_addr", waddr, 0);
        check("rst_count", wcount, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        step(1);

        // 1: reset while the write pulse is high
        load_mode = 1'b1;
        step(2);
        sw = 16'h5555;
        enter = 1'b1;
        step(1);
        check("t1_we_high", we, 1);
        check("t1_halt_high", halt, 1);
        #2 rst = 1'b1;
        #1;
        check("t1_we_rst", we, 0);
        check("t1_halt_rst", halt, 0);
        check("t1_addr_rst", waddr, 0);
        check("t1_count_rst", wcount, 0);
        enter = 1'b0;
        load_mode = 1'b0;
        step(1);
        rst = 1'b0;
        step(2);
        check("t1_idle_halt", halt, 0);
        check("t1_no_write", writes, 0);

        // 2: two words then terminator
        load_mode = 1'b1;
        step(2);
        check("t2_halt", halt, 1);
        press(16'h1234);
        press(16'h0042);
        press(16'hFFFF);
        check("t2_mem0", mem[0], 16'h1234);
        check("t2_mem1", mem[1], 16'h0042);
        check("t2_writes", writes, 2);
        check("t2_count", wcount, 2);
        check("t2_addr", waddr, 2);
        check("t2_done", done, 1);
        check("t2_disp", disp, 16'hFFFF);
        check("t2_no_ffff", ffff_writes, 0);
        check("t2_no_start_yet", starts, 0);
        load_mode = 1'b0;
        step(1);
        check("t2_start_pulse", start, 1);
        check("t2_halt_off", halt, 0);
        step(1);
        check("t2_start_gone", start, 0);
        step(2);
        check("t2_one_start", starts, 1);
        check("t2_done_kept", done, 1);

        // 3: enter held high for 50 cycles
        load_mode = 1'b1;
        step(2);
        check("t3_done_clr", done, 0);
        check("t3_count_clr", wcount, 0);
        w0 = writes;
        sw = 16'h00AA;
        enter = 1'b1;
        step(50);
        enter = 1'b0;
        step(3);
        check("t3_one_write", writes - w0, 1);
        check("t3_addr0", last_addr, 0);
        check("t3_mem0", mem[0], 16'h00AA);
        check("t3_count", wcount, 1);
        s0 = starts;
        load_mode = 1'b0;
        step(3);
        check("t3_abort_halt", halt, 0);
        check("t3_abort_count", wcount, 1);
        check("t3_abort_nostart", starts - s0, 0);

        // 5: abort in the same cycle as enter rising
        load_mode = 1'b1;
        step(2);
        w0 = writes;
        s0 = starts;
        sw = 16'h7777;
        enter = 1'b1;
        load_mode = 1'b0;
        step(1);
        check("t5_we", we, 0);
        check("t5_halt", halt, 0);
        enter = 1'b0;
        step(3);
        check("t5_no_write", writes - w0, 0);
        check("t5_no_start", starts - s0, 0);
        check("t5_idle", halt, 0);

        // 4: fill all 32 words
        load_mode = 1'b1;
        step(2);
        w0 = writes;
        s0 = starts;
        for (int i = 0; i < 31; i++) press(16'h0100 + 16'(i));
        check("t4_not_full_31", full, 0);
        check("t4_addr_31", waddr, 31);
        press(16'h011F);
        check("t4_full", full, 1);
        check("t4_writes", writes - w0, 32);
        check("t4_last_addr", last_addr, 31);
        check("t4_mem31", mem[31], 16'h011F);
        check("t4_mem5", mem[5], 16'h0105);
        check("t4_count", wcount, 32);
        check("t4_halt", halt, 1);
        press(16'h0BAD);
        check("t4_33_no_write", writes - w0, 32);
        check("t4_33_addr", waddr, 31);
        check("t4_33_count", wcount, 32);
        load_mode = 1'b0;
        step(3);
        check("t4_no_start", starts - s0, 0);
        check("t4_idle", halt, 0);
        check("t4_full_kept", full, 1);

        // 6: completed load followed by a fresh one
        load_mode = 1'b1;
        step(2);
        check("t6a_full_clr", full, 0);
        press(16'h2222);
        press(16'hFFFF);
        load_mode = 1'b0;
        step(3);
        check("t6a_done", done, 1);
        check("t6a_count", wcount, 1);
        load_mode = 1'b1;
        step(2);
        check("t6_done_clr", done, 0);
        check("t6_addr0", waddr, 0);
        check("t6_count0", wcount, 0);
        w0 = writes;
        press(16'h3333);
        check("t6_write", writes - w0, 1);
        check("t6_wr_addr", last_addr, 0);
        check("t6_mem0", mem[0], 16'h3333);
        check("t6_addr1", waddr, 1);
        load_mode = 1'b0;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
